// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master/three-slave serial bus arbiter with serial slave addressing and timeout
// Ports: clk/rstn (async active-low); m*_req, m*_addr, m*_addr_valid from the masters;
// slave_done per-slave completion pulses; bus_grant/slave_grant registered selects;
// m*_err one-cycle abort pulses; busy high outside IDLE.
module bus_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 7,
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       m1_addr,
  input  logic       m1_addr_valid,
  input  logic       m2_addr,
  input  logic       m2_addr_valid,
  input  logic [2:0] slave_done,
  output logic [1:0] bus_grant,
  output logic [2:0] slave_grant,
  output logic       m1_err,
  output logic       m2_err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ADDR, CONNECT, RELEASE} state_t;
  state_t r_state, w_state;
  logic [1:0] r_bg, w_bg, r_addr, w_addr, r_bits, w_bits;
  logic [2:0] r_sg, w_sg;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic r_e1, r_e2, w_e1, w_e2, r_busy, r_owner, w_owner, r_last, w_last;
  logic w_req, w_av, w_a, w_win_m2, w_done, w_tmo, w_rel, w_err;
  // r_owner/r_last: 0 = master 1, 1 = master 2
  assign w_req = r_owner ? m2_req : m1_req;
  assign w_av = r_owner ? m2_addr_valid : m1_addr_valid;
  assign w_a = r_owner ? m2_addr : m1_addr;
  assign w_win_m2 = m2_req & (~m1_req | (RR_EN & ~r_last));
  assign w_done = |(slave_done & {r_addr == 2'd3, r_addr == 2'd2, r_addr == 2'd1});
  assign w_tmo = r_cnt >= CNT_W'(TIMEOUT - 1);
  always_comb begin
    w_state = r_state;
    w_bg = r_bg;
    w_sg = r_sg;
    w_addr = r_addr;
    w_bits = r_bits;
    w_cnt = r_cnt + 1'b1;
    w_owner = r_owner;
    w_last = r_last;
    w_rel = 1'b0;
    w_err = 1'b0;
    w_e1 = 1'b0;
    w_e2 = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (m1_req | m2_req) begin
          w_state = ADDR;
          w_owner = w_win_m2;
          w_bg = w_win_m2 ? 2'b10 : 2'b01;
          w_addr = '0;
          w_bits = '0;
        end
      end
      ADDR: begin
        // completing the address outranks timeout; a first bit arriving on the timeout cycle does not
        if (!w_req) w_rel = 1'b1;
        else if (w_av && r_bits == 2'd1) begin
          w_addr = {r_addr[0], w_a};
          if ({r_addr[0], w_a} == 2'b00) {w_rel, w_err} = 2'b11;
          else begin
            w_state = CONNECT;
            w_sg = {r_addr[0], w_a, 1'b1};
            w_cnt = '0;
          end
        end else if (w_tmo) {w_rel, w_err} = 2'b11;
        else if (w_av) begin
          w_addr = {r_addr[0], w_a};
          w_bits = r_bits + 1'b1;
        end
      end
      CONNECT: begin
        if (w_done || !w_req) w_rel = 1'b1;
        else if (w_tmo) {w_rel, w_err} = 2'b11;
      end
      default: begin
        w_state = IDLE;
        w_last = r_owner;
        w_cnt = '0;
      end
    endcase
    if (w_rel) begin
      w_state = RELEASE;
      w_bg = 2'b00;
      w_sg = 3'b000;
      w_e1 = w_err & ~r_owner;
      w_e2 = w_err & r_owner;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_bg <= '0;
      r_sg <= '0;
      r_e1 <= 1'b0;
      r_e2 <= 1'b0;
      r_busy <= 1'b0;
      r_addr <= '0;
      r_bits <= '0;
      r_cnt <= '0;
      r_owner <= 1'b0;
      r_last <= 1'b1;
    end else begin
      r_state <= w_state;
      r_bg <= w_bg;
      r_sg <= w_sg;
      r_e1 <= w_e1;
      r_e2 <= w_e2;
      r_busy <= w_state != IDLE;
      r_addr <= w_addr;
      r_bits <= w_bits;
      r_cnt <= w_cnt;
      r_owner <= w_owner;
      r_last <= w_last;
    end
  end
  assign bus_grant = r_bg;
  assign slave_grant = r_sg;
  assign m1_err = r_e1;
  assign m2_err = r_e2;
  assign busy = r_busy;
endmodule
